cp0_issue_ctrl: RTL

CP0_ISSUE_CTRL -- requirements
Module: cp0_issue_ctrl

---
 rtl/cpu_defs_pkg.sv | 58 +++++
 rtl/cp0_issue_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs -- shared CPU type definitions.
//
// Contents:
//   rob_index_t       ROB index, including the wrap bit in the MSB
//   oper_t            decoded reservation-station operation
//   tlb_op_t          TLB operation select (TLBR/TLBWI/TLBWR/TLBP)
//   cp0_ctrl_state_t  CP0 issue-control FSM states
//   is_tlb_op()       true for the four TLB operations
//   tlb_decode()      oper_t -> tlb_op_t
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam int ROB_IDX_W = 5;

    typedef logic [ROB_IDX_W-1:0] rob_index_t;

    // TLB ops occupy the upper half of the encoding so they share op[2].
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MFC0  = 3'd1,
        OP_MTC0  = 3'd2,
        OP_ERET  = 3'd3,
        OP_TLBR  = 3'd4,
        OP_TLBWI = 3'd5,
        OP_TLBWR = 3'd6,
        OP_TLBP  = 3'd7
    } oper_t;

    typedef enum logic [1:0] {
        TLB_R  = 2'd0,
        TLB_WI = 2'd1,
        TLB_WR = 2'd2,
        TLB_P  = 2'd3
    } tlb_op_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_HEAD = 3'd1,
        TLB_START = 3'd2,
        TLB_WAIT  = 3'd3,
        RESULT    = 3'd4
    } cp0_ctrl_state_t;

    function automatic logic is_tlb_op(input oper_t op);
        is_tlb_op = op[2];
    endfunction

    function automatic tlb_op_t tlb_decode(input oper_t op);
        case (op)
            OP_TLBWI: tlb_decode = TLB_WI;
            OP_TLBWR: tlb_decode = TLB_WR;
            OP_TLBP:  tlb_decode = TLB_P;
            default:  tlb_decode = TLB_R;
        endcase
    endfunction

endpackage

// File: rtl/cp0_issue_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_issue_ctrl -- issues CP0 operations non-speculatively at the ROB head.
//
// An op offered by the CP0 reservation station is latched, held until its
// ROB index is the valid ROB head, optionally runs a TLB operation, then
// requests the CDB. rs_ack pulses for one cycle when the CDB grant lands.
//
// Build option: define CPU_TLB_EN to include the TLB_START/TLB_WAIT path
// and the TLB timeout counter. Without it, TLB ops complete like any other
// CP0 op and the TLB outputs are tied low.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               pipeline flush; kills the op in flight
//   rs_ready            RS entry busy with operands ready
//   rs_reorder, rs_op   ROB index and decoded op of the RS entry
//   rob_head(_valid)    current ROB head index and its valid flag
//   rs_ack              RS data_ack / CP0 write strobe qualifier
//   tlb_start, tlb_op   one-cycle TLB start pulse and op select
//   tlb_done            TLB operation complete
//   cdb_req/_reorder    CDB broadcast request and its ROB index
//   cdb_grant           CDB arbiter grant
//   busy                FSM not idle
//   timeout_ex          one-cycle pulse when the TLB op times out
// ---------------------------------------------------------------------------
module cp0_issue_ctrl
    import cpu_defs::*;
#(
    parameter int TLB_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       rs_ready,
    input  rob_index_t rs_reorder,
    input  oper_t      rs_op,
    input  rob_index_t rob_head,
    input  logic       rob_head_valid,
    output logic       rs_ack,
    output logic       tlb_start,
    output tlb_op_t    tlb_op,
    input  logic       tlb_done,
    output logic       cdb_req,
    output rob_index_t cdb_reorder,
    input  logic       cdb_grant,
    output logic       busy,
    output logic       timeout_ex
);

    cp0_ctrl_state_t state_q, state_d;
    rob_index_t      idx_q;
    oper_t           op_q;
    logic            latch_en;

`ifdef CPU_TLB_EN
    localparam int              CNT_W    = $clog2(TLB_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TLB_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             cnt_clr;
    logic             cnt_inc;
`else
    logic unused_tlb;
    assign unused_tlb = tlb_done ^ (TLB_TIMEOUT != 0);
`endif

    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        rs_ack     = 1'b0;
        tlb_start  = 1'b0;
        cdb_req    = 1'b0;
        timeout_ex = 1'b0;
`ifdef CPU_TLB_EN
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rs_ready) begin
                    latch_en = 1'b1;
                    state_d  = WAIT_HEAD;
                end
            end
            WAIT_HEAD: begin
                // The RS may withdraw the entry while it waits for the head.
                if (!rs_ready) begin
                    state_d = IDLE;
                end else if (rob_head_valid && (rob_head == idx_q)) begin
`ifdef CPU_TLB_EN
                    state_d = is_tlb_op(op_q) ? TLB_START : RESULT;
`else
                    state_d = RESULT;
`endif
                end
            end
`ifdef CPU_TLB_EN
            TLB_START: begin
                tlb_start = 1'b1;
                cnt_clr   = 1'b1;
                state_d   = TLB_WAIT;
            end
            TLB_WAIT: begin
                // A done arriving on the last allowed cycle wins over timeout.
                if (tlb_done) begin
                    state_d = RESULT;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_ex = 1'b1;
                    state_d    = RESULT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`endif
            RESULT: begin
                cdb_req = 1'b1;
                if (cdb_grant) begin
                    rs_ack  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush and reset kill the op in flight without acknowledging it.
        if (flush || rst) begin
            rs_ack     = 1'b0;
            tlb_start  = 1'b0;
            cdb_req    = 1'b0;
            timeout_ex = 1'b0;
            latch_en   = 1'b0;
            state_d    = IDLE;
`ifdef CPU_TLB_EN
            cnt_clr    = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                idx_q <= rs_reorder;
                op_q  <= rs_op;
            end
        end
    end

`ifdef CPU_TLB_EN
    // Saturating cycle counter for TLB_WAIT.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != CNT_LAST)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tlb_op = (!rst && ((state_q == TLB_START) || (state_q == TLB_WAIT)))
                    ? tlb_decode(op_q) : TLB_R;
`else
    assign tlb_op = TLB_R;
`endif

    assign cdb_reorder = (!rst && (state_q == RESULT)) ? idx_q : '0;
    assign busy        = !rst && (state_q != IDLE);

endmodule
